// File: rtl/address_scroller.sv
// Message scroller: a debounced step button and an auto-scroll timer both request an address
// step, which is applied only at the anode frame boundary so a frame never shows a torn message.
module address_scroller #(
    parameter int unsigned DEB_CYCLES    = 50000,
    parameter int unsigned SCROLL_CYCLES = 25000000,
    parameter int unsigned ANODE_DIV     = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button,
    input  logic       auto_en,
    output logic [3:0] anodes_counter,
    output logic [3:0] address,
    output logic [3:0] anodes,
    output logic       step_pulse
);

    localparam int unsigned DebW    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned ScrollW = (SCROLL_CYCLES > 1) ? $clog2(SCROLL_CYCLES) : 1;
    localparam int unsigned PreW    = (ANODE_DIV > 1) ? $clog2(ANODE_DIV) : 1;

    localparam logic [DebW-1:0]    DebLast    = DebW'(DEB_CYCLES - 1);
    localparam logic [ScrollW-1:0] ScrollLast = ScrollW'(SCROLL_CYCLES - 1);
    localparam logic [PreW-1:0]    PreLast    = PreW'(ANODE_DIV - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWaitHigh,
        StPressed,
        StWaitLow
    } deb_state_e;

    logic               sync1_q, sync2_q;
    deb_state_e         deb_state_q, deb_state_d;
    logic [DebW-1:0]    deb_cnt_q, deb_cnt_d;
    logic               press_evt_q, press_evt_d;

    logic [PreW-1:0]    prescaler_q, prescaler_d;
    logic [3:0]         anodes_counter_q, anodes_counter_d;
    logic [ScrollW-1:0] scroll_q, scroll_d;
    logic               pending_q, pending_d;
    logic [3:0]         address_q, address_d;
    logic               step_pulse_q, step_pulse_d;
    logic [3:0]         anodes_q, anodes_d;

    logic sync_btn;
    logic prescaler_wrap;
    logic service;
    logic scroll_evt;
    logic any_evt;

    assign sync_btn = sync2_q;

    // Debounce next-state: the counter restarts on every state entry.
    always_comb begin
        deb_state_d = deb_state_q;
        deb_cnt_d   = deb_cnt_q;
        press_evt_d = 1'b0;
        unique case (deb_state_q)
            StIdle: begin
                if (sync_btn) begin
                    deb_state_d = StWaitHigh;
                    deb_cnt_d   = '0;
                end
            end
            StWaitHigh: begin
                if (!sync_btn) begin
                    deb_state_d = StIdle;
                    deb_cnt_d   = '0;
                end else if (deb_cnt_q == DebLast) begin
                    deb_state_d = StPressed;
                    deb_cnt_d   = '0;
                    press_evt_d = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + DebW'(1);
                end
            end
            StPressed: begin
                if (!sync_btn) begin
                    deb_state_d = StWaitLow;
                    deb_cnt_d   = '0;
                end
            end
            StWaitLow: begin
                if (sync_btn) begin
                    deb_state_d = StPressed;
                    deb_cnt_d   = '0;
                end else if (deb_cnt_q == DebLast) begin
                    deb_state_d = StIdle;
                    deb_cnt_d   = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DebW'(1);
                end
            end
            default: begin
                deb_state_d = StIdle;
                deb_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            deb_state_q <= StIdle;
            deb_cnt_q   <= '0;
            press_evt_q <= 1'b0;
        end else begin
            deb_state_q <= deb_state_d;
            deb_cnt_q   <= deb_cnt_d;
            press_evt_q <= press_evt_d;
        end
    end

    always_comb begin
        prescaler_wrap   = (prescaler_q == PreLast);
        prescaler_d      = prescaler_wrap ? '0 : prescaler_q + PreW'(1);
        anodes_counter_d = prescaler_wrap ? anodes_counter_q - 4'd1 : anodes_counter_q;
        service          = prescaler_wrap && (anodes_counter_q == 4'd0);

        scroll_evt = auto_en && (scroll_q == ScrollLast);
        if (!auto_en || press_evt_q || scroll_evt) begin
            scroll_d = '0;
        end else begin
            scroll_d = scroll_q + ScrollW'(1);
        end

        // An event coinciding with service survives into the next frame.
        any_evt = press_evt_q || scroll_evt;
        if (service && pending_q) begin
            address_d    = address_q + 4'd1;
            pending_d    = any_evt;
            step_pulse_d = 1'b1;
        end else begin
            address_d    = address_q;
            pending_d    = pending_q || any_evt;
            step_pulse_d = 1'b0;
        end

        // Only the middle slot of each 4-phase digit window is lit; the rest blank.
        case (anodes_counter_d)
            4'd14:   anodes_d = 4'b0111;
            4'd10:   anodes_d = 4'b1011;
            4'd6:    anodes_d = 4'b1101;
            4'd2:    anodes_d = 4'b1110;
            default: anodes_d = 4'b1111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q          <= 1'b0;
            sync2_q          <= 1'b0;
            prescaler_q      <= '0;
            anodes_counter_q <= 4'd15;
            scroll_q         <= '0;
            pending_q        <= 1'b0;
            address_q        <= 4'd0;
            step_pulse_q     <= 1'b0;
            anodes_q         <= 4'b1111;
        end else begin
            sync1_q          <= button;
            sync2_q          <= sync1_q;
            prescaler_q      <= prescaler_d;
            anodes_counter_q <= anodes_counter_d;
            scroll_q         <= scroll_d;
            pending_q        <= pending_d;
            address_q        <= address_d;
            step_pulse_q     <= step_pulse_d;
            anodes_q         <= anodes_d;
        end
    end

    assign anodes_counter = anodes_counter_q;
    assign address        = address_q;
    assign anodes         = anodes_q;
    assign step_pulse     = step_pulse_q;

endmodule

// File: tb/tb_address_scroller.sv
// Bench for address_scroller: frame-boundary stepping, debounce, auto scroll and reset,
// checked against arithmetic models of frame timing and event servicing.
module tb_address_scroller;

    localparam int DEB   = 4;
    localparam int SCR   = 100;
    localparam int ADIV  = 2;
    localparam int FRAME = 16 * ADIV;

    logic       clk;
    logic       reset;
    logic       button;
    logic       auto_en;
    logic [3:0] anodes_counter;
    logic [3:0] address;
    logic [3:0] anodes;
    logic       step_pulse;

    int tests_run;
    int tests_failed;
    int edge_cnt;

    address_scroller #(
        .DEB_CYCLES    (DEB),
        .SCROLL_CYCLES (SCR),
        .ANODE_DIV     (ADIV)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .button         (button),
        .auto_en        (auto_en),
        .anodes_counter (anodes_counter),
        .address        (address),
        .anodes         (anodes),
        .step_pulse     (step_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Rising edges since the last edge that sampled reset high.
    always @(posedge clk) begin
        if (reset) edge_cnt <= 0;
        else       edge_cnt <= edge_cnt + 1;
    end

    // Lit digit d sits at phase 4*d+2; every other phase is blank.
    function automatic logic [3:0] an_ref(input int c);
        logic [3:0] r;
        r = 4'b1111;
        if (c % 4 == 2) r[c / 4] = 1'b0;
        return r;
    endfunction

    task automatic apply_reset(input logic auto_val);
        @(negedge clk);
        reset   = 1'b1;
        button  = 1'b0;
        auto_en = auto_val;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset   = 1'b1;
        button  = 1'b1;
        auto_en = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (address !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_address: got %0d want 0", address);
        end
        tests_run++;
        if (anodes_counter !== 4'd15) begin
            tests_failed++;
            $display("FAIL reset_counter: got %0d want 15", anodes_counter);
        end
        tests_run++;
        if (anodes !== 4'b1111) begin
            tests_failed++;
            $display("FAIL reset_anodes: got %b want 1111", anodes);
        end
        tests_run++;
        if (step_pulse !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_step: got %b want 0", step_pulse);
        end
        button = 1'b0;
        reset  = 1'b0;
        @(negedge clk);
        tests_run++;
        if (anodes !== 4'b1111) begin
            tests_failed++;
            $display("FAIL release_anodes: got %b want 1111", anodes);
        end
        tests_run++;
        if (anodes_counter !== 4'd15) begin
            tests_failed++;
            $display("FAIL release_counter: got %0d want 15", anodes_counter);
        end
    endtask

    task automatic test_anode_scan;
        int exp_cnt;
        apply_reset(1'b0);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            exp_cnt = (15 - edge_cnt / ADIV) & 15;
            tests_run++;
            if (anodes_counter !== 4'(exp_cnt)) begin
                tests_failed++;
                $display("FAIL scan_counter@%0d: got %0d want %0d", edge_cnt, anodes_counter,
                         exp_cnt);
            end
            tests_run++;
            if (anodes !== an_ref(exp_cnt)) begin
                tests_failed++;
                $display("FAIL scan_anodes@%0d: got %b want %b", edge_cnt, anodes,
                         an_ref(exp_cnt));
            end
            tests_run++;
            if (address !== 4'd0 || step_pulse !== 1'b0) begin
                tests_failed++;
                $display("FAIL scan_address@%0d: got addr %0d step %b want 0/0", edge_cnt,
                         address, step_pulse);
            end
        end
    endtask

    task automatic test_short_press;
        int steps;
        steps = 0;
        apply_reset(1'b0);
        for (int i = 0; i < 100; i++) begin
            button = (i < 3);
            @(negedge clk);
            if (step_pulse) steps++;
        end
        tests_run++;
        if (steps !== 0) begin
            tests_failed++;
            $display("FAIL short_press_steps: got %0d want 0", steps);
        end
        tests_run++;
        if (address !== 4'd0) begin
            tests_failed++;
            $display("FAIL short_press_addr: got %0d want 0", address);
        end
    endtask

    task automatic test_bounce_press;
        int steps;
        int step_edge;
        steps     = 0;
        step_edge = -1;
        apply_reset(1'b0);
        for (int i = 0; i < 100; i++) begin
            // 1,0,1,0 bounce, then 20 cycles solidly high.
            if (i < 4) button = (i % 2 == 0);
            else       button = (i < 24);
            @(negedge clk);
            if (step_pulse) begin
                steps++;
                step_edge = edge_cnt;
            end
        end
        tests_run++;
        if (steps !== 1) begin
            tests_failed++;
            $display("FAIL bounce_steps: got %0d want 1", steps);
        end
        tests_run++;
        if (step_edge !== FRAME) begin
            tests_failed++;
            $display("FAIL bounce_step_edge: got %0d want %0d", step_edge, FRAME);
        end
        tests_run++;
        if (address !== 4'd1) begin
            tests_failed++;
            $display("FAIL bounce_addr: got %0d want 1", address);
        end
    endtask

    task automatic test_double_press;
        int steps;
        int step_edge;
        steps     = 0;
        step_edge = -1;
        apply_reset(1'b0);
        for (int i = 0; i < 100; i++) begin
            button = (i < 8) || (i >= 16 && i < 24);
            @(negedge clk);
            if (step_pulse) begin
                steps++;
                step_edge = edge_cnt;
            end
        end
        tests_run++;
        if (steps !== 1 || step_edge !== FRAME) begin
            tests_failed++;
            $display("FAIL double_press: got %0d steps last@%0d want 1 step @%0d", steps,
                     step_edge, FRAME);
        end
        tests_run++;
        if (address !== 4'd1) begin
            tests_failed++;
            $display("FAIL double_press_addr: got %0d want 1", address);
        end
    endtask

    task automatic test_coincide;
        int steps;
        int step_edge;
        steps     = 0;
        step_edge = -1;
        apply_reset(1'b1);
        // Press lands next to the first scroll event at edge SCR, both inside frame (96,128].
        for (int i = 0; i < 160; i++) begin
            button = (i >= 92 && i < 104);
            @(negedge clk);
            if (step_pulse) begin
                steps++;
                step_edge = edge_cnt;
            end
        end
        tests_run++;
        if (steps !== 1 || step_edge !== 4 * FRAME) begin
            tests_failed++;
            $display("FAIL coincide: got %0d steps last@%0d want 1 step @%0d", steps,
                     step_edge, 4 * FRAME);
        end
        tests_run++;
        if (address !== 4'd1) begin
            tests_failed++;
            $display("FAIL coincide_addr: got %0d want 1", address);
        end
    endtask

    task automatic test_auto_random;
        int   t;
        int   addr_m;
        logic pend;
        logic ev;
        logic step_m;
        logic auto_cur;
        t        = 0;
        addr_m   = 0;
        pend     = 1'b0;
        auto_cur = 1'b1;
        apply_reset(1'b1);
        for (int i = 0; i < 2600; i++) begin
            auto_en = auto_cur;
            @(negedge clk);
            ev = 1'b0;
            if (!auto_cur) begin
                t = 0;
            end else if (t == SCR - 1) begin
                ev = 1'b1;
                t  = 0;
            end else begin
                t++;
            end
            step_m = 1'b0;
            if ((edge_cnt % FRAME) == 0 && pend) begin
                addr_m = (addr_m + 1) % 16;
                step_m = 1'b1;
                pend   = ev;
            end else begin
                pend = pend | ev;
            end
            tests_run++;
            if (address !== 4'(addr_m)) begin
                tests_failed++;
                $display("FAIL auto_addr@%0d: got %0d want %0d", edge_cnt, address, addr_m);
            end
            tests_run++;
            if (step_pulse !== step_m) begin
                tests_failed++;
                $display("FAIL auto_step@%0d: got %b want %b", edge_cnt, step_pulse, step_m);
            end
            if (i >= 1800 && $urandom_range(0, 99) == 0) auto_cur = ~auto_cur;
        end
    endtask

    task automatic test_random_presses;
        int hold_left;
        int gap_left;
        int presses;
        int steps;
        hold_left = 0;
        gap_left  = int'($urandom_range(5, 20));
        presses   = 0;
        steps     = 0;
        apply_reset(1'b0);
        // Presses are spaced more than a frame apart, so each one is its own step.
        for (int i = 0; i < 900; i++) begin
            if (hold_left > 0) begin
                button = 1'b1;
                hold_left--;
                if (hold_left == 0) gap_left = int'($urandom_range(34, 60));
            end else begin
                button = 1'b0;
                if (gap_left > 0) begin
                    gap_left--;
                end else if (i < 800) begin
                    presses++;
                    hold_left = int'($urandom_range(6, 20));
                end
            end
            @(negedge clk);
            if (step_pulse) begin
                steps++;
                tests_run++;
                if ((edge_cnt % FRAME) != 0 || anodes_counter !== 4'd15) begin
                    tests_failed++;
                    $display("FAIL rand_step_phase@%0d: got counter %0d want 15 on frame edge",
                             edge_cnt, anodes_counter);
                end
            end
        end
        tests_run++;
        if (steps !== presses) begin
            tests_failed++;
            $display("FAIL rand_press_steps: got %0d want %0d", steps, presses);
        end
        tests_run++;
        if (address !== 4'(presses % 16)) begin
            tests_failed++;
            $display("FAIL rand_press_addr: got %0d want %0d", address, presses % 16);
        end
    endtask

    task automatic test_reset_pending;
        int steps;
        steps = 0;
        apply_reset(1'b1);
        // Seventh step lands at edge 704; the scroll event at edge 800 leaves a step pending.
        for (int i = 0; i < 810; i++) @(negedge clk);
        tests_run++;
        if (address !== 4'd7) begin
            tests_failed++;
            $display("FAIL pend_setup_addr: got %0d want 7", address);
        end
        reset   = 1'b1;
        auto_en = 1'b0;
        button  = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (address !== 4'd0 || step_pulse !== 1'b0) begin
            tests_failed++;
            $display("FAIL pend_reset: got addr %0d step %b want 0/0", address, step_pulse);
        end
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (step_pulse) steps++;
        end
        tests_run++;
        if (steps !== 0 || address !== 4'd0) begin
            tests_failed++;
            $display("FAIL pend_after_release: got %0d steps addr %0d want 0/0", steps,
                     address);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        button       = 1'b0;
        auto_en      = 1'b0;
        test_reset();
        test_anode_scan();
        test_short_press();
        test_bounce_press();
        test_double_press();
        test_coincide();
        test_auto_random();
        test_random_presses();
        test_reset_pending();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/address_scroller.md
ADDRESS_SCROLLER -- requirements
Module: address_scroller

Interface
REQ-001 Parameter DEB_CYCLES, default 50000: consecutive stable cycles needed to accept a button level change.
REQ-002 Parameter SCROLL_CYCLES, default 25000000: cycles between automatic address steps.
REQ-003 Parameter ANODE_DIV, default 256: clk cycles per anodes_counter decrement; ANODE_DIV >= 1.
REQ-004 clk  in  1  single system clock; all state updates on posedge clk.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 button  in  1  raw asynchronous pushbutton, active-high, bouncing.
REQ-007 auto_en  in  1  1 = automatic scrolling enabled; 0 = button-only stepping.
REQ-008 anodes_counter  out  4  anode phase counter consumed by the character driver.
REQ-009 address  out  4  message start address consumed by the character driver.
REQ-010 anodes  out  4  active-low anode enables; anodes[3]=an3 ... anodes[0]=an0.
REQ-011 step_pulse  out  1  one-cycle strobe on the cycle address changes.

Function
REQ-012 button SHALL pass through a 2-flop synchronizer; only the second flop output (sync_btn) is used internally.
REQ-013 Debounce FSM states SHALL be IDLE, WAIT_HIGH, PRESSED, WAIT_LOW, with a counter cleared on every state entry.
REQ-014 IDLE -> WAIT_HIGH when sync_btn=1; WAIT_HIGH -> IDLE when sync_btn=0 before the count completes.
REQ-015 WAIT_HIGH -> PRESSED when sync_btn has been 1 for DEB_CYCLES consecutive cycles; a one-cycle press_evt is raised on that transition.
REQ-016 PRESSED -> WAIT_LOW on sync_btn=0; WAIT_LOW -> PRESSED on sync_btn=1; WAIT_LOW -> IDLE after DEB_CYCLES consecutive low cycles.
REQ-017 Each accepted press SHALL produce exactly one press_evt regardless of hold time or bounce.
REQ-018 A prescaler SHALL count 0..ANODE_DIV-1 and wrap; anodes_counter decrements by 1 (mod 16, 0 -> 15) on each prescaler wrap.
REQ-019 anodes SHALL be 4'b0111 when anodes_counter=14, 4'b1011 at 10, 4'b1101 at 6, 4'b1110 at 2, and 4'b1111 at all other values (blanking guard slots).
REQ-020 Scroll timer SHALL count while auto_en=1, raising scroll_evt and restarting from 0 on reaching SCROLL_CYCLES-1; it holds at 0 while auto_en=0.
REQ-021 press_evt or scroll_evt SHALL set a pending flag; simultaneous events, or several events before service, set it once (no accumulation).
REQ-022 press_evt SHALL restart the scroll timer from 0.
REQ-023 Pending SHALL be serviced only on the decrement from anodes_counter 0 to 15: address <= address+1 mod 16 (15 -> 0), pending cleared, step_pulse=1 that cycle.
REQ-024 An event arriving in the same cycle as service SHALL remain pending for the next frame.
REQ-025 address SHALL never change at any other anodes_counter transition.

Reset
REQ-026 While reset=1: address=0, anodes_counter=15, prescaler=0, scroll timer=0, pending=0, step_pulse=0, debounce FSM=IDLE with counter 0, synchronizer flops=0.
REQ-027 anodes SHALL equal 4'b1111 during reset and on the first cycle after release.
REQ-028 Reset asserted mid-debounce or with pending set SHALL discard the press/step; no step_pulse follows release.

Verification (DEB_CYCLES=4, SCROLL_CYCLES=100, ANODE_DIV=2 unless stated)
REQ-029 Reset release, auto_en=0, no button -> anodes_counter steps 15,14,...,0,15 every 2 cycles; anodes low only at 14/10/6/2; address stays 0.
REQ-030 button bounces 1,0,1,0 then holds high 20 cycles -> exactly one step_pulse, at the next 0->15 wrap; address 0 -> 1.
REQ-031 button high only 3 cycles -> no press_evt, address unchanged.
REQ-032 auto_en=1 for 1000 cycles from address=14 -> address sequence 14,15,0,1,...; each change coincides with a 0->15 wrap; step_pulse width 1.
REQ-033 press_evt and scroll_evt in the same cycle -> single increment; event landing on the service cycle -> increment in the following frame.
REQ-034 reset asserted while pending=1 and address=7 -> address=0, no step_pulse after release.
